// File: rtl/ps2_scancode_filter.sv
// ============================================================================
// Module   : ps2_scancode_filter
// Brief    : PS/2 set-2 prefix stripper and modifier tracker ahead of ASCII map.
//            Optional macro TYPEMATIC_FILTER_EN suppresses typematic repeats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_scancode_filter #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int PAUSE_TAIL     = 7
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic [7:0] o_scancode,
  output logic       o_valid,
  output logic       o_extended,
  output logic       o_shift,
  output logic       o_capslock
);

  localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int c_TAIL_W = $clog2(PAUSE_TAIL + 1);
  localparam logic [c_TO_W-1:0]   c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_TAIL_W-1:0] c_TAIL   = c_TAIL_W'(PAUSE_TAIL);

  localparam logic [7:0] c_EXT   = 8'hE0;
  localparam logic [7:0] c_BRK   = 8'hF0;
  localparam logic [7:0] c_PAUSE = 8'hE1;
  localparam logic [7:0] c_LSH   = 8'h12;
  localparam logic [7:0] c_RSH   = 8'h59;
  localparam logic [7:0] c_CAPS  = 8'h58;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BRK     = 3'd1,
    S_EXT     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_TAIL_W-1:0] r_tail, w_tail_nxt;
  logic [c_TO_W-1:0]   r_to_cnt, w_to_nxt;
  logic                r_shift_l, w_shift_l_nxt;
  logic                r_shift_r, w_shift_r_nxt;
  logic                r_caps, w_caps_nxt;
  logic                w_emit, w_emit_ext;
  logic                w_sup_std, w_sup_ext;
  logic                w_timeout;

`ifdef TYPEMATIC_FILTER_EN
  logic [7:0] r_last_code;
  logic       r_last_ext, r_last_vld;
  logic       w_last_wr, w_last_wr_ext, w_last_clr;

  assign w_sup_std = r_last_vld && !r_last_ext && (r_last_code == i_byte);
  assign w_sup_ext = r_last_vld &&  r_last_ext && (r_last_code == i_byte);
`else
  assign w_sup_std = 1'b0;
  assign w_sup_ext = 1'b0;
`endif

  // A strobe always takes precedence over an expiring prefix timeout.
  assign w_timeout = !i_byte_valid && (r_state != S_IDLE) && (r_to_cnt == c_TO_MAX);

  always_comb begin
    if (i_byte_valid || r_state == S_IDLE) w_to_nxt = '0;
    else if (r_to_cnt != c_TO_MAX)         w_to_nxt = r_to_cnt + c_TO_W'(1);
    else                                   w_to_nxt = r_to_cnt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tail_nxt    = r_tail;
    w_shift_l_nxt = r_shift_l;
    w_shift_r_nxt = r_shift_r;
    w_caps_nxt    = r_caps;
    w_emit        = 1'b0;
    w_emit_ext    = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
    w_last_wr     = 1'b0;
    w_last_wr_ext = 1'b0;
    w_last_clr    = 1'b0;
`endif
    if (i_byte_valid) begin
      case (r_state)
        S_IDLE: begin
          case (i_byte)
            c_EXT:   w_state_nxt = S_EXT;
            c_BRK:   w_state_nxt = S_BRK;
            c_PAUSE: begin
              w_state_nxt = S_PAUSE;
              w_tail_nxt  = c_TAIL;
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
            default: begin
`ifdef TYPEMATIC_FILTER_EN
              w_last_wr = 1'b1;
`endif
              if (!w_sup_std) begin
                case (i_byte)
                  c_LSH:   w_shift_l_nxt = 1'b1;
                  c_RSH:   w_shift_r_nxt = 1'b1;
                  c_CAPS:  w_caps_nxt    = !r_caps;
                  default: w_emit        = 1'b1;
                endcase
              end
            end
          endcase
        end
        S_BRK: begin
          if (i_byte == c_LSH) w_shift_l_nxt = 1'b0;
          if (i_byte == c_RSH) w_shift_r_nxt = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
          w_last_clr = w_sup_std;
`endif
          w_state_nxt = S_IDLE;
        end
        S_EXT: begin
          if (i_byte == c_BRK) begin
            w_state_nxt = S_EXT_BRK;
          end else begin
            w_state_nxt = S_IDLE;
            if (i_byte != c_LSH && i_byte != c_RSH) begin
`ifdef TYPEMATIC_FILTER_EN
              w_last_wr     = 1'b1;
              w_last_wr_ext = 1'b1;
`endif
              w_emit     = !w_sup_ext;
              w_emit_ext = 1'b1;
            end
          end
        end
        S_EXT_BRK: begin
`ifdef TYPEMATIC_FILTER_EN
          w_last_clr = w_sup_ext;
`endif
          w_state_nxt = S_IDLE;
        end
        S_PAUSE: begin
          w_tail_nxt = r_tail - c_TAIL_W'(1);
          if (r_tail <= c_TAIL_W'(1)) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_tail     <= '0;
      r_to_cnt   <= '0;
      r_shift_l  <= 1'b0;
      r_shift_r  <= 1'b0;
      r_caps     <= 1'b0;
      o_scancode <= 8'h00;
      o_valid    <= 1'b0;
      o_extended <= 1'b0;
    end else begin
      r_tail    <= w_tail_nxt;
      r_to_cnt  <= w_to_nxt;
      r_shift_l <= w_shift_l_nxt;
      r_shift_r <= w_shift_r_nxt;
      r_caps    <= w_caps_nxt;
      o_valid   <= w_emit;
      if (w_emit) begin
        o_scancode <= i_byte;
        o_extended <= w_emit_ext;
      end
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_last_code <= 8'h00;
      r_last_ext  <= 1'b0;
      r_last_vld  <= 1'b0;
    end else if (w_last_wr) begin
      r_last_code <= i_byte;
      r_last_ext  <= w_last_wr_ext;
      r_last_vld  <= 1'b1;
    end else if (w_last_clr) begin
      r_last_vld  <= 1'b0;
    end
  end
`endif

  assign o_shift    = r_shift_l | r_shift_r;
  assign o_capslock = r_caps;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scancode_filter.sv
// ============================================================================
// Module   : tb_ps2_scancode_filter
// Brief    : Directed scoreboard bench for ps2_scancode_filter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_scancode_filter;

  localparam int c_TO = 20;

  logic       clk = 1'b0;
  logic       i_sclr = 1'b1;
  logic [7:0] i_byte = 8'h00;
  logic       i_byte_valid = 1'b0;
  logic [7:0] o_scancode;
  logic       o_valid, o_extended, o_shift, o_capslock;

  int n_checks = 0;
  int n_fails  = 0;

  // expected {code, ext, shift, caps} per o_valid pulse
  logic [10:0] exp_q[$];

  ps2_scancode_filter #(.TIMEOUT_CYCLES(c_TO), .PAUSE_TAIL(7)) dut (
    .clk(clk), .i_sclr(i_sclr), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_scancode(o_scancode), .o_valid(o_valid), .o_extended(o_extended),
    .o_shift(o_shift), .o_capslock(o_capslock)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    i_byte       = b;
    i_byte_valid = 1'b1;
    @(posedge clk);
    #1;
    i_byte_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic expect_emit(input logic [7:0] code, input logic ext, input logic sh, input logic cp);
    exp_q.push_back({code, ext, sh, cp});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_sclr = 1'b1;
    @(posedge clk);
    #1;
    i_sclr = 1'b0;
  endtask

  // Monitor: every o_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (o_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_emit: got code=%h ext=%b, expected no output", o_scancode, o_extended);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if ({o_scancode, o_extended, o_shift, o_capslock} !== e) begin
          n_fails++;
          $display("FAIL emit: got code=%h ext=%b sh=%b cp=%b, expected code=%h ext=%b sh=%b cp=%b",
                   o_scancode, o_extended, o_shift, o_capslock, e[10:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    idle(2);
    do_reset();
    check("reset_outputs", {5'd0, o_scancode, o_valid, o_extended, o_shift, o_capslock}, 16'h0000);

    expect_emit(8'h1C, 1'b0, 1'b0, 1'b0);
    send(8'h1C);
    check("plain_levels", {14'd0, o_shift, o_capslock}, 16'h0000);
    idle(1);
    check("valid_one_cycle", {15'd0, o_valid}, 16'h0000);

    send(8'h12);
    check("lshift_set", {15'd0, o_shift}, 16'h0001);
    expect_emit(8'h1C, 1'b0, 1'b1, 1'b0);
    send_seq('{8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12});
    check("lshift_clear", {15'd0, o_shift}, 16'h0000);

    send_seq('{8'h59, 8'h12, 8'hF0, 8'h12});
    check("rshift_held", {15'd0, o_shift}, 16'h0001);
    send_seq('{8'hF0, 8'h59});
    check("rshift_clear", {15'd0, o_shift}, 16'h0000);

    send_seq('{8'h58, 8'hF0, 8'h58});
    check("capslock_on", {15'd0, o_capslock}, 16'h0001);

    expect_emit(8'h5A, 1'b1, 1'b0, 1'b1);
    send_seq('{8'hE0, 8'h5A});
    send_seq('{8'hE0, 8'hF0, 8'h5A});
    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
    check("pause_mods", {14'd0, o_shift, o_capslock}, 16'h0001);
    send_seq('{8'hE0, 8'h12, 8'hAA, 8'hFA});
    check("fake_shift", {15'd0, o_shift}, 16'h0001 ^ 16'h0001);

    // Strobe on the timeout cycle is still consumed by the break.
    send(8'hF0);
    idle(c_TO - 1);
    send(8'h1C);
    // Full timeout abandons the break.
    send(8'hF0);
    idle(c_TO);
    expect_emit(8'h1C, 1'b0, 1'b0, 1'b1);
    send(8'h1C);

    send(8'hE0);
    do_reset();
    check("reset_mid_caps", {15'd0, o_capslock}, 16'h0000);
    expect_emit(8'h5A, 1'b0, 1'b0, 1'b0);
    send(8'h5A);

    i_sclr = 1'b1;
    send(8'h1C);
    i_sclr = 1'b0;
    check("reset_beats_strobe", {15'd0, o_valid}, 16'h0000);

`ifdef TYPEMATIC_FILTER_EN
    expect_emit(8'h1C, 1'b0, 1'b0, 1'b0);
    expect_emit(8'h1C, 1'b0, 1'b0, 1'b0);
`else
    repeat (4) expect_emit(8'h1C, 1'b0, 1'b0, 1'b0);
`endif
    send_seq('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C});
    send_seq('{8'h58, 8'h58});
`ifdef TYPEMATIC_FILTER_EN
    check("caps_repeat", {15'd0, o_capslock}, 16'h0001);
`else
    check("caps_repeat", {15'd0, o_capslock}, 16'h0000);
`endif

    expect_emit(8'h1C, 1'b0, 1'b0, o_capslock);
    expect_emit(8'h32, 1'b0, 1'b0, o_capslock);
    expect_emit(8'h21, 1'b0, 1'b0, o_capslock);
    send_seq('{8'h1C, 8'h32, 8'h21});

    idle(4);
    check("scoreboard_empty", 16'(exp_q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
